alu_seq: RTL and testbench

Parametrised successor to the single-cycle ALU of the LEGv8 datapath. It keeps the existing opcode map, widens the datapath to WIDTH bits and adds shifts and an iterative multiplier. A valid/ready handshake on both sides lets the controller stall the pipeline while a multi-cycle operation completes. It sits between operand prep (input1/input2) and the data cache and PC (result, zero_flag).

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bus of alu_seq: operands and opcode in, registered result and flags out.
// Both directions use valid/ready; master is the controller side, slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             neg_flag;
    logic             carry_flag;
    logic             ovf_flag;
    logic             illegal_op;

    modport master (
        output in_valid, input1, input2, opcode, out_ready,
        input  in_ready, out_valid, result, zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op
    );

    modport slave (
        input  in_valid, input1, input2, opcode, out_ready,
        output in_ready, out_valid, result, zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op
    );
endinterface

// File: rtl/alu_seq.sv
// LEGv8-opcode ALU with shifts, iterative MUL and optional UDIV (enabled by macro ALU_SEQ_DIV_EN).
// Latency 1 (simple ops), WIDTH/MUL_STEP+1 (MUL), WIDTH+1 (UDIV); in_ready low while busy or result stalled.
module alu_seq #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input logic       clock,
    input logic       reset,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH / MUL_STEP);

    localparam logic [3:0] OP_ADD = 4'd2,  OP_SUB = 4'd3,  OP_ORR  = 4'd4,  OP_NOR = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6,  OP_CBZ = 4'd7,  OP_LSL  = 4'd8,  OP_EOR = 4'd9;
    localparam logic [3:0] OP_LSR = 4'd10, OP_MUL = 4'd11, OP_NAND = 4'd12, OP_MOV = 4'd13;

`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd14;
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, HOLD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd3} state_t;
`endif

    state_t             state;
    logic               out_vld_q;
    logic [WIDTH-1:0]   res_q;
    logic               z_q, n_q, c_q, v_q, ill_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic               in_rdy, accept;
    logic [WIDTH-1:0]   a, b, op_res;
    logic [WIDTH:0]     sum, diff;
    logic               op_c, op_v, op_z, op_n, op_ill, op_cbz, op_mul;
    logic [2*WIDTH-1:0] mul_add, mul_acc_nxt;

    assign in_rdy = (state == IDLE) && (!out_vld_q || bus.out_ready);
    assign accept = bus.in_valid && in_rdy;

    always_comb begin
        a      = bus.input1;
        b      = bus.input2;
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        op_ill = 1'b0;
        op_cbz = 1'b0;
        op_mul = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = diff[WIDTH-1:0];
                op_c   = diff[WIDTH];
                op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ORR:  op_res = a | b;
            OP_NOR:  op_res = ~(a | b);
            OP_AND:  op_res = a & b;
            OP_CBZ: begin
                op_res = a;
                op_cbz = 1'b1;
            end
            OP_LSL:  op_res = a << b[SW-1:0];
            OP_EOR:  op_res = a ^ b;
            OP_LSR:  op_res = a >> b[SW-1:0];
            OP_MUL:  op_mul = 1'b1;
            OP_NAND: op_res = ~(a & b);
            OP_MOV:  op_res = b;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV:  ;
`endif
            default: op_ill = 1'b1;
        endcase
        op_z = !op_ill && (op_res == '0);
        op_n = !op_ill && !op_cbz && op_res[WIDTH-1];
    end

    // Shift-and-add: retire MUL_STEP multiplier bits per cycle.
    always_comb begin
        mul_add = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) mul_add = mul_add + (mcand << i);
        end
        mul_acc_nxt = acc + mul_add;
    end

`ifdef ALU_SEQ_DIV_EN
    // acc holds {remainder, dividend/quotient}; the shifted remainder needs WIDTH+1 bits.
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_acc_nxt;
    always_comb begin
        rem_sh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_sub     = rem_sh - {1'b0, mplier};
        div_ge      = rem_sh >= {1'b0, mplier};
        div_acc_nxt = {div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_vld_q <= 1'b0;
            res_q     <= '0;
            {z_q, n_q, c_q, v_q, ill_q} <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && op_mul) begin
                        state     <= MUL;
                        out_vld_q <= 1'b0;
                        acc       <= '0;
                        mcand     <= {{WIDTH{1'b0}}, bus.input1};
                        mplier    <= bus.input2;
                        cnt       <= MUL_ITERS;
`ifdef ALU_SEQ_DIV_EN
                    end else if (accept && bus.opcode == OP_DIV) begin
                        state     <= DIV;
                        out_vld_q <= 1'b0;
                        acc       <= {{WIDTH{1'b0}}, bus.input1};
                        mplier    <= bus.input2;
                        cnt       <= CW'(WIDTH);
`endif
                    end else if (accept) begin
                        out_vld_q <= 1'b1;
                        res_q     <= op_res;
                        {z_q, n_q, c_q, v_q, ill_q} <= {op_z, op_n, op_c, op_v, op_ill};
                    end else if (out_vld_q && bus.out_ready) begin
                        out_vld_q <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= mul_acc_nxt;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= HOLD;
                        out_vld_q <= 1'b1;
                        res_q     <= mul_acc_nxt[WIDTH-1:0];
                        z_q       <= (mul_acc_nxt[WIDTH-1:0] == '0);
                        n_q       <= mul_acc_nxt[WIDTH-1];
                        c_q       <= 1'b0;
                        v_q       <= |mul_acc_nxt[2*WIDTH-1:WIDTH];
                        ill_q     <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                DIV: begin
                    acc <= div_acc_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= HOLD;
                        out_vld_q <= 1'b1;
                        res_q     <= div_acc_nxt[WIDTH-1:0];
                        z_q       <= (div_acc_nxt[WIDTH-1:0] == '0);
                        n_q       <= div_acc_nxt[WIDTH-1];
                        c_q       <= 1'b0;
                        v_q       <= (mplier == '0);
                        ill_q     <= 1'b0;
                    end
                end
`endif
                HOLD: begin
                    if (bus.out_ready) begin
                        out_vld_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = out_vld_q;
    assign bus.result     = res_q;
    assign bus.zero_flag  = z_q;
    assign bus.neg_flag   = n_q;
    assign bus.carry_flag = c_q;
    assign bus.ovf_flag   = v_q;
    assign bus.illegal_op = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32, MUL_STEP=1); follows ALU_SEQ_DIV_EN for opcode 14.
module tb_alu_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one single-cycle op (in_valid stays high for back-to-back use) and check its result.
    task automatic sc(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic c, input logic v, input logic z,
                      input logic n, input logic ill);
        bus.opcode   = op;
        bus.input1   = a;
        bus.input2   = b;
        bus.in_valid = 1'b1;
        tick();
        check({tag, "_vld"}, bus.out_valid, 1);
        check({tag, "_res"}, bus.result, res);
        check({tag, "_flags"}, {bus.carry_flag, bus.ovf_flag, bus.zero_flag, bus.neg_flag, bus.illegal_op},
              {c, v, z, n, ill});
        check({tag, "_rdy"}, bus.in_ready, 1);
    endtask

    // Issue a multi-cycle op and count cycles until out_valid (accept cycle -> out_valid cycle).
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic rdy_seen);
        bus.opcode   = op;
        bus.input1   = a;
        bus.input2   = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat          = 1;
        rdy_seen     = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    initial begin
        int   lat;
        logic rdy_seen;
        logic vld_seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode    = 4'd0;
        bus.input1    = '0;
        bus.input2    = '0;

        tick();
        tick();
        check("rst_vld", bus.out_valid, 0);
        check("rst_res", bus.result, 0);
        check("rst_flags", {bus.zero_flag, bus.neg_flag, bus.carry_flag, bus.ovf_flag, bus.illegal_op}, 0);
        check("rst_rdy", bus.in_ready, 1);
        reset = 1'b0;
        tick();

        // Back-to-back single-cycle ops, one result per cycle.
        sc("add15",   4'd2,  32'd15,        32'd15,        32'd30,        0, 0, 0, 0, 0);
        sc("sub_ovf", 4'd3,  32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000000,  0, 1, 0, 1, 0);
        sc("add_c",   4'd2,  32'hFFFFFFFF,  32'd1,         32'd0,         1, 0, 1, 0, 0);
        sc("add_ovf", 4'd2,  32'h7FFFFFFF,  32'd1,         32'h80000000,  0, 1, 0, 1, 0);
        sc("sub_nb",  4'd3,  32'd5,         32'd3,         32'd2,         1, 0, 0, 0, 0);
        sc("sub_bor", 4'd3,  32'd3,         32'd5,         32'hFFFFFFFE,  0, 0, 0, 1, 0);
        sc("orr",     4'd4,  32'd5,         32'd15,        32'd15,        0, 0, 0, 0, 0);
        sc("nor",     4'd5,  32'd0,         32'd0,         32'hFFFFFFFF,  0, 0, 0, 1, 0);
        sc("and",     4'd6,  32'hC,         32'hA,         32'h8,         0, 0, 0, 0, 0);
        sc("cbz0",    4'd7,  32'd0,         32'd99,        32'd0,         0, 0, 1, 0, 0);
        sc("cbz3",    4'd7,  32'd3,         32'd0,         32'd3,         0, 0, 0, 0, 0);
        sc("lsl_msk", 4'd8,  32'd1,         32'd36,        32'd16,        0, 0, 0, 0, 0);
        sc("eor",     4'd9,  32'hF0F0,      32'hFF00,      32'h0FF0,      0, 0, 0, 0, 0);
        sc("lsr31",   4'd10, 32'h80000000,  32'd31,        32'd1,         0, 0, 0, 0, 0);
        sc("lsr_msk", 4'd10, 32'h80000000,  32'd32,        32'h80000000,  0, 0, 0, 1, 0);
        sc("nand",    4'd12, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         0, 0, 1, 0, 0);
        sc("mov",     4'd13, 32'd5,         32'h1234,      32'h1234,      0, 0, 0, 0, 0);
        sc("ill0",    4'd0,  32'd5,         32'd5,         32'd0,         0, 0, 0, 0, 1);
        sc("ill15",   4'd15, 32'd0,         32'd0,         32'd0,         0, 0, 0, 0, 1);
`ifndef ALU_SEQ_DIV_EN
        sc("ill14",   4'd14, 32'd100,       32'd7,         32'd0,         0, 0, 0, 0, 1);
`endif
        bus.in_valid = 1'b0;
        tick();
        check("idle_vld", bus.out_valid, 0);

        // Iterative multiply.
        check("mul_issue_rdy", bus.in_ready, 1);
        run_long(4'd11, 32'h10000, 32'h10000, lat, rdy_seen);
        check("mul_lat", lat, 33);
        check("mul_busy_rdy", rdy_seen, 0);
        check("mul_res", bus.result, 0);
        check("mul_ovf", {bus.ovf_flag, bus.zero_flag, bus.carry_flag, bus.illegal_op}, 4'b1100);
        check("mul_hold_rdy", bus.in_ready, 0);
        tick();
        check("mul_drop", bus.out_valid, 0);
        run_long(4'd11, 32'd1234, 32'd5678, lat, rdy_seen);
        check("mul2_res", bus.result, 32'd7006652);
        check("mul2_ovf", bus.ovf_flag, 0);
        tick();
        run_long(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rdy_seen);
        check("mul3_res", bus.result, 32'd1);
        check("mul3_ovf", bus.ovf_flag, 1);
        tick();

        // Output backpressure: result held, next op waits until out_ready.
        bus.out_ready = 1'b0;
        bus.opcode    = 4'd4;
        bus.input1    = 32'd5;
        bus.input2    = 32'd15;
        bus.in_valid  = 1'b1;
        tick();
        bus.opcode = 4'd2;
        bus.input1 = 32'd1;
        bus.input2 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            check("bp_res", bus.result, 32'd15);
            check("bp_vld_rdy", {bus.out_valid, bus.in_ready}, 2'b10);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_rdy", bus.in_ready, 1);
        tick();
        check("bp_next_res", bus.result, 32'd2);
        check("bp_next_vld", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        tick();
        check("bp_drop", bus.out_valid, 0);

        // Reset during MUL cycle 10.
        bus.opcode   = 4'd11;
        bus.input1   = 32'd3;
        bus.input2   = 32'd5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check("mrst_vld", bus.out_valid, 0);
        check("mrst_res", bus.result, 0);
        check("mrst_flags", {bus.zero_flag, bus.neg_flag, bus.carry_flag, bus.ovf_flag, bus.illegal_op}, 0);
        check("mrst_rdy", bus.in_ready, 1);
        #3;
        reset = 1'b0;
        vld_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) vld_seen = 1'b1;
        end
        check("mrst_no_stale", vld_seen, 0);

`ifdef ALU_SEQ_DIV_EN
        run_long(4'd14, 32'd100, 32'd7, lat, rdy_seen);
        check("div_lat", lat, 33);
        check("div_res", bus.result, 32'd14);
        check("div_ovf", bus.ovf_flag, 0);
        tick();
        run_long(4'd14, 32'd100, 32'd0, lat, rdy_seen);
        check("div0_lat", lat, 33);
        check("div0_res", bus.result, 32'hFFFFFFFF);
        check("div0_ovf", bus.ovf_flag, 1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
